// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add controller for an unsigned W x W multiply.
// Sequences one external W-bit adder over W steps to build a 2W-bit product.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b operand handshake (multiplicand a, multiplier b)
//   out_valid/out_ready/out_p   product handshake, out_p = {H, Q}
//   add_a/add_b                 adder operands (accumulator, gated multiplicand)
//   add_sum/add_cout            adder result (same cycle, or next cycle if ADD_PIPE=1)
//   busy                        high in every state except IDLE
module mul_seq_ctrl #(
  parameter int unsigned W        = 8,
  parameter int unsigned ADD_PIPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_sum,
  input  logic           add_cout,
  output logic           busy
);

  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  m_q, h_q, q_q;
  logic [W-1:0]  m_d, h_d, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step;
  logic          last;

  // The step that sees cnt = W-1 is the W-th and final one.
  assign last = (cnt_q == CW'(W - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m_q   <= '0;
      h_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      m_q   <= m_d;
      h_q   <= h_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    m_d       = m_q;
    h_d       = h_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          m_d       = in_a;
          q_d       = in_b;
          h_d       = '0;
          cnt_d     = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // With a registered adder, RUN only presents operands; WAIT consumes the result.
        if (ADD_PIPE == 0) begin
          step      = 1'b1;
          state_nxt = last ? DONE : RUN;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        step      = 1'b1;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Shift {cout, sum, Q} right by one: sum LSB becomes the next product low bit.
    if (step) begin
      h_d   = {add_cout, add_sum[W-1:1]};
      q_d   = {add_sum[0], q_q[W-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Outputs decoded from registers only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_p     = {h_q, q_q};
  assign add_a     = h_q;
  assign add_b     = q_q[0] ? m_q : '0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed, table-driven check of mul_seq_ctrl with a
// combinational adder (ADD_PIPE=0) and a registered adder (ADD_PIPE=1).
module tb_mul_seq_ctrl;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           out_ready;
  logic [W-1:0]   in_a, in_b;

  logic           in_valid0, in_ready0, out_valid0, busy0, cout0;
  logic [2*W-1:0] out_p0;
  logic [W-1:0]   add_a0, add_b0, sum0;

  logic           in_valid1, in_ready1, out_valid1, busy1;
  logic [2*W-1:0] out_p1;
  logic [W-1:0]   add_a1, add_b1;
  logic [W:0]     add_r1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Combinational adder for the ADD_PIPE=0 instance.
  assign {cout0, sum0} = {1'b0, add_a0} + {1'b0, add_b0};

  // Registered adder for the ADD_PIPE=1 instance, reset to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) add_r1 <= '0;
    else      add_r1 <= {1'b0, add_a1} + {1'b0, add_b1};
  end

  mul_seq_ctrl #(.W(W), .ADD_PIPE(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_p(out_p0),
    .add_a(add_a0), .add_b(add_b0), .add_sum(sum0), .add_cout(cout0),
    .busy(busy0)
  );

  mul_seq_ctrl #(.W(W), .ADD_PIPE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_p(out_p1),
    .add_a(add_a1), .add_b(add_b1), .add_sum(add_r1[W-1:0]), .add_cout(add_r1[W]),
    .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction on the ADD_PIPE=0 instance.
  task automatic run0(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp, input int stall, input bit tog);
    int lat;
    bit busy_ok, hold_ok;
    @(negedge clk);
    in_a = a; in_b = b; in_valid0 = 1'b1; out_ready = 1'b0;
    chk({nm, " in_ready before accept"}, 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid0 && lat < 100) begin
      if (!busy0 || in_ready0) busy_ok = 1'b0;
      if (tog) begin
        in_valid0 = ~in_valid0;
        in_a = W'($urandom);
        in_b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid0 = 1'b0;
    if (!busy0) busy_ok = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'(W + 1));
    chk({nm, " busy during op"}, 32'(busy_ok), 32'd1);
    chk({nm, " out_p"}, 32'(out_p0), 32'(exp));
    hold_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (out_p0 !== exp || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    if (stall > 0) chk({nm, " stall hold"}, 32'(hold_ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after handshake"}, 32'(out_valid0), 32'd0);
    chk({nm, " in_ready after handshake"}, 32'(in_ready0), 32'd1);
  endtask

  typedef struct {
    string          nm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             stall;
    bit             tog;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  lat;
    bit  pair_ok, idle_ok;
    logic [W-1:0] pa, pb;

    vecs[0] = '{"13x11",   8'd13,  8'd11,  16'h008F, 0, 1'b0};
    vecs[1] = '{"255x255", 8'd255, 8'd255, 16'hFE01, 0, 1'b0};
    vecs[2] = '{"0x200",   8'd0,   8'd200, 16'h0000, 0, 1'b0};
    vecs[3] = '{"1x255",   8'd1,   8'd255, 16'h00FF, 0, 1'b0};
    vecs[4] = '{"100x100", 8'd100, 8'd100, 16'h2710, 5, 1'b0};
    vecs[5] = '{"12x12",   8'd12,  8'd12,  16'h0090, 0, 1'b1};

    rst = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready0), 32'd1);
    chk("reset out_valid", 32'(out_valid0), 32'd0);
    chk("reset out_p", 32'(out_p0), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset add_a/add_b", 32'({add_a0, add_b0}), 32'd0);
    chk("reset pipe1 outputs", 32'({out_valid1, busy1, out_p1}), 32'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run0(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].stall, vecs[i].tog);

    // No further accept or product after the toggled-operand run.
    idle_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid0 || !in_ready0 || busy0) idle_ok = 1'b0;
    end
    chk("12x12 no second product", 32'(idle_ok), 32'd1);

    // Reset during step 4 of 50x50.
    @(negedge clk);
    in_a = 8'd50; in_b = 8'd50; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid0), 32'd0);
    chk("midreset in_ready", 32'(in_ready0), 32'd1);
    chk("midreset busy", 32'(busy0), 32'd0);
    chk("midreset out_p", 32'(out_p0), 32'd0);
    chk("midreset add_a/add_b", 32'({add_a0, add_b0}), 32'd0);
    @(negedge clk); rst = 1'b1;
    run0("7x9", 8'd7, 8'd9, 16'h003F, 0, 1'b0);

    // Registered adder: 200x3 on the ADD_PIPE=1 instance.
    @(negedge clk);
    in_a = 8'd200; in_b = 8'd3; in_valid1 = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 1;
    pair_ok = 1'b1;
    pa = '0; pb = '0;
    while (!out_valid1 && lat < 100) begin
      // Odd cycles are RUN, even cycles are the matching WAIT.
      if (lat % 2 == 1) begin
        pa = add_a1; pb = add_b1;
      end else if (add_a1 !== pa || add_b1 !== pb) begin
        pair_ok = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("pipe1 latency", 32'(lat), 32'(2 * W + 1));
    chk("pipe1 out_p", 32'(out_p1), 32'h0258);
    chk("pipe1 add stable RUN->WAIT", 32'(pair_ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pipe1 out_valid after handshake", 32'(out_valid1), 32'd0);
    chk("pipe1 in_ready after handshake", 32'(in_ready1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Iterative shift-add controller for an unsigned W×W multiply. It sequences a single shared W-bit adder (a gpk-based carry-lookahead adder, combinational or pipelined) over W steps to produce a 2W-bit product. It sits between a valid/ready operand source and a valid/ready result sink. It owns the accumulator, multiplier shift register, step counter and FSM; the adder is external.

## Interface
- `W`, default 8: operand width, ≥2.
- `ADD_PIPE`, default 0: adder latency. 0 means `add_sum`/`add_cout` are valid in the same cycle as `add_a`/`add_b`. 1 means they are valid one cycle later, with the adder registered and its registers reset to 0.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  W  multiplicand.
- `in_b`  in  W  multiplier.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  sink accepts product.
- `out_p`  out  2W  product.
- `add_a`  out  W  adder operand A; always the accumulator H.
- `add_b`  out  W  adder operand B; the multiplicand register M when `Q[0]` is 1, else 0.
- `add_sum`  in  W  adder sum.
- `add_cout`  in  1  adder carry-out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Registers:
  - M (W bits): latched multiplicand.
  - H (W bits): accumulator high half.
  - Q (W bits): multiplier, becomes the product low half.
  - Step counter `cnt`, width $clog2(W)+1.
  - FSM state.
- States: IDLE, RUN, WAIT (exists only when ADD_PIPE=1), DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: M←`in_a`, Q←`in_b`, H←0, `cnt`←0, go to RUN.
- RUN, ADD_PIPE=0: every cycle performs one step.
  - Take {`add_cout`, `add_sum`}.
  - H←{`add_cout`, `add_sum`[W-1:1]}.
  - Q←{`add_sum`[0], Q[W-1:1]}.
  - `cnt`←`cnt`+1.
  - When `cnt`=W-1 at the step edge, go to DONE.
- RUN, ADD_PIPE=1: holds `add_a`/`add_b` for one cycle, then goes to WAIT.
- WAIT: performs the step update as above, sampling the adder result registered from the previous cycle. It then goes to RUN, or to DONE after the W-th step.
- `add_a`/`add_b` derive only from registers and stay stable from RUN through its WAIT.
- DONE:
  - `out_valid`=1 and `out_p`={H,Q}.
  - Hold until `out_valid & out_ready`, then go to IDLE.
  - `out_p` stays stable while stalled.
- `in_ready` is 1 only in IDLE. `in_valid` in any other state is ignored, and `in_a`/`in_b` are not sampled.
- Arithmetic:
  - Unsigned. The product always fits in 2W bits.
  - All W steps execute regardless of operand values (zero operands are not skipped).
- Reset asserted in any state:
  - Immediately returns to IDLE and the in-flight operation is discarded.
  - M, H, Q and `cnt` clear to 0.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_p`=0, `busy`=0, `add_a`=0, `add_b`=0.
- Latency, counted from the accept edge to the first cycle with `out_valid`=1:
  - ADD_PIPE=0: W+1 cycles (W RUN cycles, then DONE).
  - ADD_PIPE=1: 2W+1 cycles.
- Earliest next accept is the cycle after the output handshake. Throughput is one product per W+2 cycles (ADD_PIPE=0) or 2W+2 cycles (ADD_PIPE=1) with `out_ready` tied high.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register, with no combinational path from inputs.
- The output handshake is completed by the edge where `out_valid & out_ready` are both 1. `out_valid` is 0 in the following cycle.

## Test plan
- ADD_PIPE=0, W=8, operands 13×11:
  - `out_p`=0x008F.
  - `out_valid` rises exactly 9 cycles after the accept edge.
  - `busy`=1 throughout.
- ADD_PIPE=0, corner operands:
  - 255×255 gives 0xFE01.
  - 0×200 gives 0x0000.
  - 1×255 gives 0x00FF.
  - All three take identical latency.
- Backpressure on 100×100:
  - Hold `out_ready`=0 for 5 cycles.
  - Required: `out_p`=0x2710 stable, `in_ready`=0 throughout.
  - After the handshake, `in_ready`=1 in the next cycle.
- ADD_PIPE=1 with a registered adder model, 200×3:
  - `out_p`=0x0258, `out_valid` 17 cycles after accept.
  - `add_a`/`add_b` are unchanged across each RUN→WAIT pair.
- Reset mid-operation:
  - Assert `rst` low during step 4 of 50×50.
  - Required: `out_valid`=0, `in_ready`=1, all outputs 0.
  - After release, 7×9 yields 0x003F.
- Operand changes while busy:
  - Toggle `in_valid`, `in_a` and `in_b` mid-operation for 12×12.
  - Required: result 0x0090, no extra accept, no second `out_valid`.
